// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with centre sampling,
// a one-entry valid/ready output buffer and sticky error flags.
module uart_rx_core #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk_in,
    input  logic       sys_rstn,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF = BAUD_DIV / 2;
    localparam logic [15:0] HALF_M1 = 16'(HALF - 1);
    localparam logic [15:0] BAUD_M1 = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [1:0]  sync_q;
    logic        rxd_s;
    logic        done;
    logic        ferr_set;
    logic        ovr_set;

    assign rxd_s = sync_q[1];
    assign busy  = (state_q != IDLE);

    // Two-flop synchronizer; idles high so reset looks like a quiet line.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) sync_q <= 2'b11;
        else           sync_q <= {sync_q[0], uart_rxd};
    end

    // Receive FSM state, bit timer, bit index and shift register.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    // Next-state logic: half-bit to the start centre, then full bits.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        done     = 1'b0;
        ferr_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == BAUD_M1) begin
                    shreg_d[idx_q] = rxd_s;
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == BAUD_M1) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = BRK;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            BRK: begin
                if (rxd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ovr_set = done && rx_valid && !rx_ready;

    // Output buffer: a new byte may replace one consumed this cycle.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (done && (!rx_valid || rx_ready)) begin
            rx_data  <= shreg_q;
            rx_valid <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    // Sticky error flags; a set event beats a clear in the same cycle.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ferr_set)     frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (ovr_set)      overrun   <= 1'b1;
            else if (err_clr) overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed bench for uart_rx_core at BAUD_DIV=16,
// inputs driven on the falling clock edge, outputs sampled there too.
module tb_uart_rx_core;

    localparam int BD = 16;

    logic       clk_in;
    logic       sys_rstn;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       err_clr;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int lat;

    uart_rx_core #(.BAUD_DIV(BD)) dut (
        .clk_in    (clk_in),
        .sys_rstn  (sys_rstn),
        .uart_rxd  (uart_rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .err_clr   (err_clr),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk_in = 1'b0;
    always #20 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_rxd = 1'b0;
        cyc(BD);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            cyc(BD);
        end
        uart_rxd = 1'b1;
        cyc(BD);
        cyc(4);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!rx_valid && n < 400) begin
            @(negedge clk_in);
            n++;
        end
    endtask

    task automatic pop();
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
    endtask

    initial begin
        sys_rstn = 1'b0;
        uart_rxd = 1'b0;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        cyc(3);
        chk("rst_data", rx_data, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_busy", busy, 0);

        // line held low straight out of reset
        sys_rstn = 1'b1;
        cyc(2);
        chk("rel_busy2", busy, 0);
        cyc(1);
        chk("rel_busy3", busy, 1);
        cyc(200);
        chk("brk_ferr", frame_err, 1);
        chk("brk_valid", rx_valid, 0);
        chk("brk_busy", busy, 1);
        uart_rxd = 1'b1;
        cyc(5);
        chk("brk_exit", busy, 0);
        send_byte(8'hA5);
        chk("a5_valid", rx_valid, 1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_ferr", frame_err, 1);
        clr_err();
        chk("a5_fclr", frame_err, 0);
        pop();
        chk("a5_pop", rx_valid, 0);

        // single byte with latency measurement
        rx_ready = 1'b1;
        fork
            send_byte(8'h5A);
            begin
                wait_valid(lat);
                chk("5a_lat", lat, 2 + 1 + 8 + 9 * BD);
                chk("5a_data", rx_data, 8'h5A);
                cyc(1);
                chk("5a_pulse", rx_valid, 0);
                chk("5a_ferr", frame_err, 0);
            end
        join
        rx_ready = 1'b0;

        // overrun
        send_byte(8'h31);
        send_byte(8'h32);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_data", rx_data, 8'h31);
        chk("ovr_flag", overrun, 1);
        pop();
        chk("ovr_pop", rx_valid, 0);
        clr_err();
        chk("ovr_clr", overrun, 0);

        // 4-cycle glitch
        uart_rxd = 1'b0;
        cyc(4);
        uart_rxd = 1'b1;
        cyc(2);
        chk("gl_busy", busy, 1);
        cyc(6);
        chk("gl_idle", busy, 0);
        cyc(20);
        chk("gl_valid", rx_valid, 0);
        chk("gl_ferr", frame_err, 0);
        chk("gl_ovr", overrun, 0);

        // reset in the middle of bit 3
        fork
            send_byte(8'hFF);
            begin
                cyc(BD + 3 * BD + BD / 2);
                chk("mid_busy", busy, 1);
                sys_rstn = 1'b0;
                #1;
                chk("mid_rbusy", busy, 0);
                chk("mid_rvalid", rx_valid, 0);
                chk("mid_rdata", rx_data, 0);
                cyc(5);
                sys_rstn = 1'b1;
            end
        join
        cyc(4);
        chk("mid_novalid", rx_valid, 0);
        send_byte(8'h81);
        chk("81_valid", rx_valid, 1);
        chk("81_data", rx_data, 8'h81);
        chk("81_ferr", frame_err, 0);
        pop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
